// File: rtl/cic_comp_pkg.sv
// Shared types and constants for the CIC droop compensator.
// Coefficients are Q2.16 signed; DEFAULT_COEFFS targets a 4-stage, R=8 decimator.
package cic_comp_pkg;

  localparam int COEFF_FRAC = 16;
  localparam int COEFF_BITS = 18;
  localparam int MAX_TAPS   = 32;

  typedef logic signed [COEFF_BITS-1:0] coeff_t;

  typedef enum logic [1:0] {IDLE, MAC, DONE} comp_state_e;

  // Symmetric inverse-sinc kernel; the taps sum to unity DC gain (65536).
  localparam coeff_t DEFAULT_COEFFS [15] = '{
    -18'sd120,  18'sd240,  -18'sd480,  18'sd920, -18'sd1750, 18'sd3400, -18'sd7800,
     18'sd76716,
    -18'sd7800, 18'sd3400, -18'sd1750, 18'sd920, -18'sd480,  18'sd240,  -18'sd120
  };

  function automatic int acc_width(input int nb_in, input int taps);
    return nb_in + COEFF_BITS + $clog2(taps);
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = COEFF_BITS,
  parameter int ACC_W = 38
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk_i) begin
    if (!reset_i || clr) acc <= '0;
    else if (en)         acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/cic_compensator.sv
// Time-multiplexed single-MAC FIR flattening CIC passband droop.
// One result per input tick; latency num_taps+2 cycles.
module cic_compensator
  import cic_comp_pkg::*;
#(
  parameter int     num_taps        = 15,
  parameter int     num_bits_input  = 16,
  parameter int     num_bits_output = 16,
  parameter coeff_t coeffs [num_taps] = DEFAULT_COEFFS
)(
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              tick_i,
  input  logic signed [num_bits_input-1:0]  signal_i,
  output logic signed [num_bits_output-1:0] signal_o,
  output logic                              tick_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int NI    = num_bits_input;
  localparam int NO    = num_bits_output;
  localparam int ACC_W = acc_width(NI, num_taps);
  localparam int IDX_W = $clog2(num_taps);
  localparam int S     = COEFF_FRAC + NI - NO;
  localparam int RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] HALF = $signed({{(RW-S){1'b0}}, 1'b1, {(S-1){1'b0}}});
  localparam logic signed [RW-1:0] OMAX = $signed({{(RW-NO+1){1'b0}}, {(NO-1){1'b1}}});
  localparam logic signed [RW-1:0] OMIN = $signed({{(RW-NO+1){1'b1}}, {(NO-1){1'b0}}});

  comp_state_e                     state;
  logic [IDX_W-1:0]                idx;
  logic [num_taps-1:0][NI-1:0]     x;
  logic signed [NI-1:0]            x_sel;
  coeff_t                          c_sel;
  logic signed [ACC_W-1:0]         acc;
  logic signed [RW-1:0]            rnd;
  logic signed [NO-1:0]            sat_val;
  logic                            accept;

  assign accept = (state == IDLE) && tick_i;

  // Newest sample enters x[0]; ticks arriving while busy never touch the line.
  always_ff @(posedge clk_i) begin
    if (!reset_i)    x <= '0;
    else if (accept) x <= {x[num_taps-2:0], signal_i};
  end

  assign x_sel = $signed(x[idx]);
  assign c_sel = coeffs[idx];

  cic_comp_mac #(
    .A_W   (NI),
    .B_W   (COEFF_BITS),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (accept),
    .en      (state == MAC),
    .a       (x_sel),
    .b       (c_sel),
    .acc     (acc)
  );

  // One extra bit keeps the rounding offset from wrapping at the accumulator ceiling.
  assign rnd = (RW'(acc) + HALF) >>> S;

  always_comb begin
    sat_val = rnd[NO-1:0];
    if (rnd > OMAX)      sat_val = OMAX[NO-1:0];
    else if (rnd < OMIN) sat_val = OMIN[NO-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      idx       <= '0;
      signal_o  <= '0;
      tick_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      tick_o    <= 1'b0;
      overrun_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick_i) begin
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          overrun_o <= tick_i;
          idx       <= idx + 1'b1;
          if (idx == IDX_W'(num_taps - 1)) state <= DONE;
        end
        DONE: begin
          overrun_o <= tick_i;
          signal_o  <= sat_val;
          tick_o    <= 1'b1;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_compensator.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop and compare.
module tb_cic_compensator;
  import cic_comp_pkg::*;

  localparam int NT = 4;
  localparam coeff_t CA [NT] = '{18'sd65536, 18'sd32768, -18'sd16384, 18'sd0};
  localparam coeff_t CB [NT] = '{18'sd32768, 18'sd0, 18'sd0, 18'sd0};

  typedef struct { int val; int cyc; } exp_t;

  logic               clk, rst_n;
  logic               tick_a, tick_b;
  logic signed [15:0] sig_a, sig_b, out_a, out_b;
  logic               tko_a, tko_b, busy_a, busy_b, ovr_a, ovr_b;

  exp_t q_a[$], q_b[$];
  exp_t ea, eb;
  int   passed, total, cyc, ovr_cnt_a, ovr_cnt_b;
  longint xm [NT];
  longint cm [NT] = '{65536, 32768, -16384, 0};

  cic_compensator #(.num_taps(NT), .num_bits_input(16), .num_bits_output(16), .coeffs(CA)) dut_a (
    .clk_i(clk), .reset_i(rst_n), .tick_i(tick_a), .signal_i(sig_a),
    .signal_o(out_a), .tick_o(tko_a), .busy_o(busy_a), .overrun_o(ovr_a));

  cic_compensator #(.num_taps(NT), .num_bits_input(16), .num_bits_output(16), .coeffs(CB)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .tick_i(tick_b), .signal_i(sig_b),
    .signal_o(out_b), .tick_o(tko_b), .busy_o(busy_b), .overrun_o(ovr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function void check(input string name, input longint act, input longint exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endfunction

  // Reference model for dut_a: full-precision dot product, round half up, clamp.
  function automatic int model_step(input int v);
    longint s;
    for (int k = NT-1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = v;
    s = 0;
    for (int k = 0; k < NT; k++) s += xm[k] * cm[k];
    s = (s + 32768) >>> 16;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic send(input bit to_b, input int v, input int exp_v, input bit use_model, input int gap);
    exp_t e;
    int   m;
    @(posedge clk); #1;
    e.cyc = cyc + NT + 2;
    if (to_b) begin
      sig_b = 16'(v); tick_b = 1'b1;
      e.val = exp_v; q_b.push_back(e);
    end else begin
      sig_a = 16'(v); tick_a = 1'b1;
      m = model_step(v);
      e.val = use_model ? m : exp_v; q_a.push_back(e);
    end
    @(posedge clk); #1;
    tick_a = 1'b0; tick_b = 1'b0;
    repeat (gap-2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tko_a) begin
        if (q_a.size() == 0) begin
          total++;
          $display("FAIL a_spurious_tick: got tick_o=1 value %0d expected no output (cycle %0d)", out_a, cyc);
        end else begin
          ea = q_a.pop_front();
          check("a_value", out_a, ea.val);
          check("a_latency", cyc, ea.cyc);
        end
      end
      if (tko_b) begin
        if (q_b.size() == 0) begin
          total++;
          $display("FAIL b_spurious_tick: got tick_o=1 value %0d expected no output (cycle %0d)", out_b, cyc);
        end else begin
          eb = q_b.pop_front();
          check("b_value", out_b, eb.val);
          check("b_latency", cyc, eb.cyc);
        end
      end
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  initial begin
    int c0;
    passed = 0; total = 0; cyc = 0; ovr_cnt_a = 0; ovr_cnt_b = 0;
    for (int k = 0; k < NT; k++) xm[k] = 0;
    rst_n = 1'b0; tick_a = 1'b0; tick_b = 1'b0; sig_a = '0; sig_b = '0;

    // Reset for 3 cycles with a tick that must be ignored.
    @(posedge clk); #1; tick_a = 1'b1; sig_a = 16'sd1234;
    @(posedge clk); #1; tick_a = 1'b0;
    @(posedge clk); #1;
    check("rst_signal", out_a, 0);
    check("rst_tick", tko_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_overrun", ovr_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_tick_ignored_busy", busy_a, 0);

    // Impulse response.
    send(0, 1000, 1000, 0, 8);
    send(0, 0, 500, 0, 8);
    send(0, 0, -250, 0, 8);
    send(0, 0, 0, 0, 8);
    send(0, 0, 0, 0, 8);

    // Saturation and rounding of negative full scale.
    send(0, 30000, 30000, 0, 8);
    send(0, 30000, 32767, 0, 8);
    send(0, 0, 7500, 0, 8);
    send(0, 0, -7500, 0, 8);
    send(0, 0, 0, 0, 8);
    send(0, 0, 0, 0, 8);
    send(0, -32768, -32768, 0, 8);
    send(0, 0, -16384, 0, 8);
    send(0, 0, 8192, 0, 8);
    send(0, 0, 0, 0, 8);
    send(0, 0, 0, 0, 8);

    // Overrun: second tick 3 cycles after the first is dropped.
    @(posedge clk); #1;
    c0 = cyc; sig_a = 16'sd200; tick_a = 1'b1;
    ea.val = model_step(200); ea.val = 200; ea.cyc = c0 + NT + 2; q_a.push_back(ea);
    @(posedge clk); #1; tick_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; sig_a = 16'sd777; tick_a = 1'b1;
    @(posedge clk); #1; tick_a = 1'b0;
    check("ovr_pulse", ovr_a, 1);
    check("ovr_busy", busy_a, 1);
    @(posedge clk); #1;
    check("ovr_single_cycle", ovr_a, 0);
    repeat (2) @(posedge clk);
    send(0, 0, 100, 0, 8);
    send(0, 0, -50, 0, 8);
    send(0, 0, 0, 0, 8);
    send(0, 0, 0, 0, 8);

    // Back-to-back at minimum spacing, random data against the model.
    for (int i = 0; i < 20; i++) send(0, int'($signed(16'($urandom))), 0, 1, NT + 2);
    repeat (NT + 2) @(posedge clk);
    check("b2b_no_overrun", ovr_cnt_a, 1);

    // Reset two cycles after an accepted tick aborts the computation.
    @(posedge clk); #1; sig_a = 16'sd5000; tick_a = 1'b1;
    @(posedge clk); #1; tick_a = 1'b0;
    check("midmac_busy", busy_a, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("midmac_signal", out_a, 0);
    check("midmac_busy_clr", busy_a, 0);
    check("midmac_tick", tko_a, 0);
    for (int k = 0; k < NT; k++) xm[k] = 0;
    repeat (3) @(posedge clk);
    send(0, 1000, 1000, 0, 8);
    send(0, 0, 500, 0, 8);
    send(0, 0, -250, 0, 8);
    send(0, 0, 0, 0, 8);

    // Round-half-up with a 0.5 gain tap.
    send(1, 1, 1, 0, 8);
    send(1, -1, 0, 0, 8);
    send(1, 3, 2, 0, 8);
    send(1, -3, -1, 0, 8);

    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      total += q_a.size() + q_b.size();
      $display("FAIL drain: got %0d/%0d outstanding results expected 0", q_a.size(), q_b.size());
    end
    @(posedge clk); #1;
    check("overrun_count_a", ovr_cnt_a, 1);
    check("overrun_count_b", ovr_cnt_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
